mc_control: RTL and testbench



---
 rtl/mc_control_pkg.sv | 70 +++++++
 rtl/alu_dec.sv | 29 ++
 rtl/mc_control.sv | 154 +++++++++++++++
 tb/tb_mc_control.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, funct codes, ALU codes.
// Defining MC_CONTROL_BNE_EN adds the bne opcode and its BNE state.
package mc_control_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
`ifdef MC_CONTROL_BNE_EN
        ,
        BNE     = 4'd12
`endif
    } stateT;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       pcWrite;
        logic       branch;
`ifdef MC_CONTROL_BNE_EN
        logic       branchNe;
`endif
        logic       iorD;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic [1:0] aluOp;
    } ctrlT;

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps the FSM's ALUOp plus the funct field onto the 3-bit ALU operation code.
module alu_dec
    import mc_control_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [5:0] funct,
    output logic [2:0] aluControl
);

    // ALUOp 11 is never produced by the FSM; it falls back to add like 00.
    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  aluControl = ALU_ADD;
                    FN_SUB:  aluControl = ALU_SUB;
                    FN_AND:  aluControl = ALU_AND;
                    FN_OR:   aluControl = ALU_OR;
                    FN_SLT:  aluControl = ALU_SLT;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control unit: Moore FSM driving the datapath around reg_file, plus ALU decoder.
// Defining MC_CONTROL_BNE_EN adds bne support through state BNE (12).
module mc_control
    import mc_control_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               PCEn,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [2:0]         ALUControl,
    output logic [STATE_W-1:0] State
);

    stateT state;
    stateT nextState;
    ctrlT  ctrl;
    logic  branchTaken;

    // Unused encodings decode to all-zero controls, so no write can fire from a corrupted state.
    function automatic ctrlT decodeState(input stateT s);
        ctrlT c;
        c       = '0;
        c.aluOp = ALUOP_ADD;
        case (s)
            FETCH: begin
                c.aluSrcB = 2'b01;
                c.irWrite = 1'b1;
                c.pcWrite = 1'b1;
            end
            DECODE:  c.aluSrcB = 2'b11;
            MEMADR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
            end
            MEMRD:   c.iorD = 1'b1;
            MEMWB: begin
                c.memtoReg = 1'b1;
                c.regWrite = 1'b1;
            end
            MEMWR: begin
                c.iorD     = 1'b1;
                c.memWrite = 1'b1;
            end
            EXECUTE: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.regDst   = 1'b1;
                c.regWrite = 1'b1;
            end
            BEQ: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = ALUOP_SUB;
                c.pcSrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
            end
            ADDIWB:  c.regWrite = 1'b1;
            JUMP: begin
                c.pcSrc   = 2'b10;
                c.pcWrite = 1'b1;
            end
`ifdef MC_CONTROL_BNE_EN
            BNE: begin
                c.aluSrcA  = 1'b1;
                c.aluOp    = ALUOP_SUB;
                c.pcSrc    = 2'b01;
                c.branchNe = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    // Unknown opcodes return straight to FETCH from DECODE without touching state elsewhere.
    always_comb begin
        nextState = FETCH;
        case (state)
            FETCH:  nextState = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXECUTE;
                    OP_BEQ:       nextState = BEQ;
                    OP_ADDI:      nextState = ADDIEX;
                    OP_J:         nextState = JUMP;
`ifdef MC_CONTROL_BNE_EN
                    OP_BNE:       nextState = BNE;
`endif
                    default:      nextState = FETCH;
                endcase
            end
            MEMADR:  nextState = (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   nextState = MEMWB;
            EXECUTE: nextState = ALUWB;
            ADDIEX:  nextState = ADDIWB;
            default: nextState = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    assign ctrl = decodeState(state);

`ifdef MC_CONTROL_BNE_EN
    assign branchTaken = (ctrl.branch & Zero) | (ctrl.branchNe & ~Zero);
`else
    assign branchTaken = ctrl.branch & Zero;
`endif

    // Write enables are masked during reset so an interrupted instruction never commits.
    assign PCEn     = ~reset & (ctrl.pcWrite | branchTaken);
    assign MemWrite = ~reset & ctrl.memWrite;
    assign IRWrite  = ~reset & ctrl.irWrite;
    assign RegWrite = ~reset & ctrl.regWrite;
    assign IorD     = ctrl.iorD;
    assign RegDst   = ctrl.regDst;
    assign MemtoReg = ctrl.memtoReg;
    assign ALUSrcA  = ctrl.aluSrcA;
    assign ALUSrcB  = ctrl.aluSrcB;
    assign PCSrc    = ctrl.pcSrc;
    assign State    = STATE_W'(state);

    alu_dec uAluDec (
        .aluOp      (ctrl.aluOp),
        .funct      (Funct),
        .aluControl (ALUControl)
    );

endmodule

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control against an instruction-level reference model.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic [14:0] obsVec;

    int checks   = 0;
    int failures = 0;

    mc_control #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    always #5 clk = ~clk;

    assign obsVec = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                     ALUSrcA, ALUSrcB, PCSrc, ALUControl};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ALU operation the funct field names for an R-type instruction.
    function automatic logic [2:0] aluFor(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Each instruction class walks a fixed path of states (one hex digit per cycle).
    function automatic void pathFor(input logic [5:0] op, output logic [31:0] path,
                                    output int len, output int writes);
        writes = 0;
        case (op)
            6'b100011: begin path = 32'h01234; len = 5; writes = 1; end
            6'b101011: begin path = 32'h0125;  len = 4; end
            6'b000000: begin path = 32'h0167;  len = 4; writes = 1; end
            6'b000100: begin path = 32'h018;   len = 3; end
            6'b001000: begin path = 32'h019A;  len = 4; writes = 1; end
            6'b000010: begin path = 32'h01B;   len = 3; end
`ifdef MC_CONTROL_BNE_EN
            6'b000101: begin path = 32'h01C;   len = 3; end
`endif
            default:   begin path = 32'h01;    len = 2; end
        endcase
    endfunction

    // Expected control word in a given step of an instruction.
    function automatic logic [14:0] expOut(input int st, input logic [5:0] fn, input logic z);
        logic pcWrite, pcEn, iorD, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA;
        logic [1:0] aluSrcB, pcSrc;
        logic [2:0] aluCtl;
        logic isBranch;
        pcWrite  = (st == 0) || (st == 11);
        isBranch = (st == 8);
        pcEn     = pcWrite || (st == 8 && z);
`ifdef MC_CONTROL_BNE_EN
        isBranch = isBranch || (st == 12);
        pcEn     = pcEn || (st == 12 && !z);
`endif
        iorD     = (st == 3) || (st == 5);
        memWrite = (st == 5);
        irWrite  = (st == 0);
        regDst   = (st == 7);
        memtoReg = (st == 4);
        regWrite = (st == 4) || (st == 7) || (st == 10);
        aluSrcA  = (st == 2) || (st == 6) || (st == 9) || isBranch;
        aluSrcB  = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 :
                   ((st == 2) || (st == 9)) ? 2'b10 : 2'b00;
        pcSrc    = isBranch ? 2'b01 : (st == 11) ? 2'b10 : 2'b00;
        aluCtl   = (st == 6) ? aluFor(fn) : isBranch ? 3'b110 : 3'b010;
        return {pcEn, iorD, memWrite, irWrite, regDst, memtoReg, regWrite,
                aluSrcA, aluSrcB, pcSrc, aluCtl};
    endfunction

    // Runs one instruction from FETCH; zeroMode < 0 randomizes Zero every cycle.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input int zeroMode);
        logic [31:0] path;
        int len, writes, seen, st;
        pathFor(op, path, len, writes);
        Op    = op;
        Funct = fn;
        seen  = 0;
        for (int k = 0; k < len; k++) begin
            Zero = (zeroMode < 0) ? 1'($urandom) : 1'(zeroMode);
            st   = int'((path >> (4 * (len - 1 - k))) & 32'hF);
            @(negedge clk);
            checkOutput($sformatf("state op=%b step%0d", op, k), 32'(State), 32'(st));
            checkOutput($sformatf("ctrl op=%b st=%0d", op, st), 32'(obsVec), 32'(expOut(st, fn, Zero)));
            seen += int'(RegWrite);
            @(posedge clk);
            #1;
        end
        checkOutput($sformatf("regwrite_count op=%b", op), 32'(seen), 32'(writes));
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        int aborted;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b000010, 6'b000101, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset = 1'b1;
        Op    = '0;
        Funct = '0;
        Zero  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("reset_state", 32'(State), 32'd0);
            checkOutput("reset_writes", 32'({RegWrite, MemWrite, IRWrite, PCEn}), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(6'b100011, 6'b000000, -1);
        applyStimulus(6'b000000, 6'b100010, -1);
        applyStimulus(6'b000100, 6'b000000, 1);
        applyStimulus(6'b000100, 6'b000000, 0);
        applyStimulus(6'b111111, 6'b000000, -1);
        applyStimulus(6'b000101, 6'b000000, 0);

        // Abort a lw in MEMRD: its register write must never appear.
        Op      = 6'b100011;
        aborted = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            aborted += int'(RegWrite);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_in_memrd", 32'(State), 32'd3);
        aborted += int'(RegWrite);
        checkOutput("abort_writes_masked", 32'({RegWrite, MemWrite, IRWrite, PCEn}), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("abort_state", 32'(State), 32'd0);
        aborted += int'(RegWrite);
        checkOutput("abort_regwrite", 32'(aborted), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(6'b100011, 6'b000000, -1);

        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            applyStimulus(op, fn, -1);
        end

        @(negedge clk);
        checkOutput("final_state", 32'(State), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
